// File: rtl/grid_ctrl.sv
// Run controller for the sudoku grid: clears the grid, launches the tile chain,
// times the run and holds the outcome until the host acknowledges it.
module grid_ctrl #(
  parameter int CNT_W        = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             abort,
  input  logic [CNT_W-1:0] timeout_limit,
  input  logic             grid_success,
  input  logic             grid_failure,
  output logic             grid_reset,
  output logic             grid_start,
  output logic             busy,
  output logic             result_valid,
  output logic             result_ok,
  output logic             result_timeout,
  output logic             result_abort,
  input  logic             result_ack,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0]       CLR_LOAD = 4'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [3:0]       clr_cnt;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cycles_plus1;
  logic [CNT_W-1:0] cycles_sat;
  logic             limit_hit;

  // The wrapped +1 never equals a nonzero limit once saturated, so a timeout
  // can only fire at or before the saturation point.
  assign cycles_plus1 = cycles + CNT_W'(1);
  assign cycles_sat   = (cycles == CNT_MAX) ? cycles : cycles_plus1;
  assign limit_hit    = (limit != '0) && (cycles_plus1 == limit);

  // Decoding from the state register lets async reset drop these at once.
  assign grid_reset   = (state == CLEAR);
  assign grid_start   = (state == LAUNCH);
  assign busy         = (state == CLEAR) || (state == LAUNCH) || (state == RUN);
  assign result_valid = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      clr_cnt        <= '0;
      limit          <= '0;
      cycles         <= '0;
      result_ok      <= 1'b0;
      result_timeout <= 1'b0;
      result_abort   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state   <= CLEAR;
            clr_cnt <= CLR_LOAD;
          end
        end
        CLEAR: begin
          if (abort) begin
            state          <= DONE;
            cycles         <= '0;
            result_ok      <= 1'b0;
            result_timeout <= 1'b0;
            result_abort   <= 1'b1;
          end else if (clr_cnt == 4'd0) begin
            state <= LAUNCH;
          end else begin
            clr_cnt <= clr_cnt - 4'd1;
          end
        end
        LAUNCH: begin
          cycles         <= '0;
          limit          <= timeout_limit;
          result_ok      <= 1'b0;
          result_timeout <= 1'b0;
          result_abort   <= abort;
          state          <= abort ? DONE : RUN;
        end
        RUN: begin
          cycles <= cycles_sat;
          if (abort) begin
            state        <= DONE;
            result_abort <= 1'b1;
          end else if (grid_success) begin
            state     <= DONE;
            result_ok <= 1'b1;
          end else if (grid_failure) begin
            state <= DONE;
          end else if (limit_hit) begin
            state          <= DONE;
            result_timeout <= 1'b1;
          end
        end
        DONE: begin
          if (result_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
